// File: rtl/mux_arb_nto1_if.sv
// Handshake bundle for the N-to-1 arbitrating mux.
// slave = arbiter side, master = producers plus consumer.
interface mux_arb_nto1_if #(
    parameter int WIDTH = 32,
    parameter int CH    = 4
);
    localparam int SEL_W = (CH > 1) ? $clog2(CH) : 1;

    logic [CH-1:0]       data_i_valid;
    logic [CH*WIDTH-1:0] data_i;
    logic [CH-1:0]       data_i_ready;
    logic                data_o_valid;
    logic [WIDTH-1:0]    data_o;
    logic [SEL_W-1:0]    data_o_sel;
    logic                data_o_ready;

    modport slave (
        input  data_i_valid, data_i, data_o_ready,
        output data_i_ready, data_o_valid, data_o, data_o_sel
    );

    modport master (
        output data_i_valid, data_i, data_o_ready,
        input  data_i_ready, data_o_valid, data_o, data_o_sel
    );
endinterface

// File: rtl/mux_arb_nto1.sv
// N-to-1 arbitrating mux with registered output and valid/ready handshakes.
// MUX_ARB_RR_EN selects round-robin; otherwise fixed priority (lowest index).
module mux_arb_nto1 #(
    parameter int WIDTH = 32,
    parameter int CH    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_arb_nto1_if.slave bus
);
    localparam int SEL_W = (CH > 1) ? $clog2(CH) : 1;

    logic             load_en;
    logic             xfer;
    logic             found;
    logic [CH-1:0]    grant;
    logic [SEL_W-1:0] gidx;

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] sel_q, sel_d;
`ifdef MUX_ARB_RR_EN
    logic [SEL_W-1:0] ptr_q, ptr_d;
`endif

    // First requester at or above the priority pointer, wrapping.
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        for (int k = 0; k < CH; k++) begin
            int idx;
`ifdef MUX_ARB_RR_EN
            idx = int'(ptr_q) + k;
            if (idx >= CH) idx = idx - CH;
`else
            idx = k;
`endif
            if (!found && bus.data_i_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gidx       = SEL_W'(idx);
            end
        end
    end

    assign load_en          = !valid_q || bus.data_o_ready;
    assign bus.data_i_ready = (rst_n && load_en) ? grant : '0;
    assign xfer             = |bus.data_i_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        sel_d   = sel_q;
`ifdef MUX_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        if (xfer) begin
            valid_d = 1'b1;
            data_d  = bus.data_i[int'(gidx)*WIDTH +: WIDTH];
            sel_d   = gidx;
`ifdef MUX_ARB_RR_EN
            ptr_d   = (gidx == SEL_W'(CH-1)) ? '0 : gidx + SEL_W'(1);
`endif
        end else if (load_en) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
`ifdef MUX_ARB_RR_EN
            ptr_q   <= '0;
`endif
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
`ifdef MUX_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign bus.data_o_valid = valid_q;
    assign bus.data_o       = data_q;
    assign bus.data_o_sel   = sel_q;
endmodule
